// File: rtl/click_decoder.sv
// Click gesture decoder: groups debounced press pulses into single/double/triple+ gestures and
// presents each closed gesture over a valid/ready handshake.
// Optional statistics counters are enabled by defining CLICK_DECODER_STATS_EN.
module click_decoder #(
  parameter int unsigned GAP_W      = 16,
  parameter int unsigned GAP_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_l,
  input  logic       btn_db,
  input  logic       evt_ready,
  output logic       evt_valid,
  output logic [1:0] evt_code,
  output logic       drop
`ifdef CLICK_DECODER_STATS_EN
  ,
  output logic [7:0] evt_cnt,
  output logic [7:0] drop_cnt
`endif
);

  localparam logic [GAP_W-1:0] GapLast = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StCount = 2'b01
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         clicks_q, clicks_d;
  logic [GAP_W-1:0]   timer_q, timer_d;
  logic               close;
  logic               evt_valid_q, evt_valid_d;
  logic [1:0]         evt_code_q, evt_code_d;
  logic               drop_q, drop_d;
  logic               accept;

  assign accept = evt_valid_q & evt_ready;

  // Gesture FSM next state: count pulses, close after a full idle gap.
  always_comb begin
    state_d  = state_q;
    clicks_d = clicks_q;
    timer_d  = timer_q;
    close    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (btn_db) begin
          state_d  = StCount;
          clicks_d = 2'd1;
          timer_d  = '0;
        end
      end
      StCount: begin
        if (btn_db) begin
          // A pulse in the expiry cycle wins and restarts the gap.
          clicks_d = (clicks_q == 2'd3) ? 2'd3 : clicks_q + 2'd1;
          timer_d  = '0;
        end else if (timer_q == GapLast) begin
          close    = 1'b1;
          state_d  = StIdle;
          clicks_d = 2'd0;
          timer_d  = '0;
        end else begin
          timer_d = timer_q + GAP_W'(1);
        end
      end
      default: begin
        state_d  = StIdle;
        clicks_d = 2'd0;
        timer_d  = '0;
      end
    endcase
  end

  // Output slot next state: retire accepted events, load or drop closed gestures.
  always_comb begin
    evt_valid_d = evt_valid_q;
    evt_code_d  = evt_code_q;
    drop_d      = 1'b0;
    if (accept) begin
      evt_valid_d = 1'b0;
      evt_code_d  = 2'b00;
    end
    if (close) begin
      if (!evt_valid_q || evt_ready) begin
        evt_valid_d = 1'b1;
        evt_code_d  = clicks_q;
      end else begin
        drop_d = 1'b1;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q     <= StIdle;
      clicks_q    <= 2'd0;
      timer_q     <= '0;
      evt_valid_q <= 1'b0;
      evt_code_q  <= 2'b00;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      clicks_q    <= clicks_d;
      timer_q     <= timer_d;
      evt_valid_q <= evt_valid_d;
      evt_code_q  <= evt_code_d;
      drop_q      <= drop_d;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_code  = evt_code_q;
  assign drop      = drop_q;

`ifdef CLICK_DECODER_STATS_EN
  logic [7:0] evt_cnt_q, drop_cnt_q;

  // Saturating counters of accepted transfers and discarded gestures.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      evt_cnt_q  <= 8'd0;
      drop_cnt_q <= 8'd0;
    end else begin
      if (accept && evt_cnt_q != 8'hff) evt_cnt_q <= evt_cnt_q + 8'd1;
      if (drop_d && drop_cnt_q != 8'hff) drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  assign evt_cnt  = evt_cnt_q;
  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_click_decoder.sv
// Directed bench for click_decoder with GAP_CYCLES=8; cycle N means the rising edge N after
// the per-test origin, and outputs are sampled on the following falling edge.
module tb_click_decoder;

  localparam int unsigned GapW   = 16;
  localparam int unsigned GapCyc = 8;

  logic       clk = 1'b0;
  logic       rst_l = 1'b0;
  logic       btn_db = 1'b0;
  logic       evt_ready = 1'b1;
  logic       evt_valid;
  logic [1:0] evt_code;
  logic       drop;
`ifdef CLICK_DECODER_STATS_EN
  logic [7:0] evt_cnt;
  logic [7:0] drop_cnt;
`endif

  click_decoder #(
    .GAP_W     (GapW),
    .GAP_CYCLES(GapCyc)
  ) dut (
    .clk      (clk),
    .rst_l    (rst_l),
    .btn_db   (btn_db),
    .evt_ready(evt_ready),
    .evt_valid(evt_valid),
    .evt_code (evt_code),
    .drop     (drop)
`ifdef CLICK_DECODER_STATS_EN
    ,
    .evt_cnt  (evt_cnt),
    .drop_cnt (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  int unsigned base = 0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to the falling edge after rising edge n of the current test.
  task automatic at(input int unsigned n);
    while (cyc < base + n) @(negedge clk);
    if (cyc != base + n) check("schedule", cyc, base + n);
  endtask

  task automatic start();
    @(negedge clk);
    base = cyc;
  endtask

  // Pulse sampled by rising edge n.
  task automatic pulse(input int unsigned n);
    at(n - 1);
    btn_db = 1'b1;
    at(n);
    btn_db = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_valid", evt_valid, 0);
    check("rst_code", evt_code, 0);
    check("rst_drop", drop, 0);
`ifdef CLICK_DECODER_STATS_EN
    check("rst_evt_cnt", evt_cnt, 0);
    check("rst_drop_cnt", drop_cnt, 0);
`endif
    rst_l = 1'b1;

    // 1: single pulse
    start();
    pulse(10);
    at(17); check("t1_v17", evt_valid, 0);
    at(18); check("t1_v18", evt_valid, 1); check("t1_code", evt_code, 2'b01);
    at(19); check("t1_v19", evt_valid, 0); check("t1_code19", evt_code, 0);

    // 2: double
    start();
    pulse(10);
    pulse(14);
    at(18); check("t2_v18", evt_valid, 0);
    at(21); check("t2_v21", evt_valid, 0);
    at(22); check("t2_v22", evt_valid, 1); check("t2_code", evt_code, 2'b10);
    at(23); check("t2_v23", evt_valid, 0);
    at(40); check("t2_v40", evt_valid, 0);

    // 3: five pulses saturate at triple
    start();
    for (int i = 0; i < 5; i++) pulse(10 + 2 * i);
    at(25); check("t3_v25", evt_valid, 0);
    at(26); check("t3_v26", evt_valid, 1); check("t3_code", evt_code, 2'b11);
    at(27); check("t3_v27", evt_valid, 0);

    // 4: pulse in the expiry cycle extends the gesture
    start();
    pulse(10);
    pulse(18);
    at(19); check("t4_v19", evt_valid, 0);
    at(25); check("t4_v25", evt_valid, 0);
    at(26); check("t4_v26", evt_valid, 1); check("t4_code", evt_code, 2'b10);
    at(27); check("t4_v27", evt_valid, 0);

    // 5: back-pressure, second gesture dropped
    start();
    evt_ready = 1'b0;
    pulse(10);
    at(18); check("t5_v18", evt_valid, 1); check("t5_code18", evt_code, 2'b01);
    pulse(30);
    at(37); check("t5_drop37", drop, 0);
    at(38); check("t5_drop38", drop, 1); check("t5_code38", evt_code, 2'b01);
    at(39); check("t5_drop39", drop, 0);
    at(40); check("t5_v40", evt_valid, 1); check("t5_code40", evt_code, 2'b01);
`ifdef CLICK_DECODER_STATS_EN
    check("t5_drop_cnt", drop_cnt, 1);
    check("t5_evt_cnt0", evt_cnt, 0);
`endif
    evt_ready = 1'b1;
    at(41); check("t5_v41", evt_valid, 0); check("t5_code41", evt_code, 0);
`ifdef CLICK_DECODER_STATS_EN
    check("t5_evt_cnt1", evt_cnt, 1);
`endif
    at(50); check("t5_v50", evt_valid, 0);

    // 6: reset mid-gesture discards it
    start();
    pulse(10);
    at(14);
    rst_l = 1'b0;
    #1;
    check("t6_rst_valid", evt_valid, 0);
    check("t6_rst_code", evt_code, 0);
    at(16);
    rst_l = 1'b1;
    at(18); check("t6_v18", evt_valid, 0);
    at(26); check("t6_v26", evt_valid, 0);
    pulse(30);
    at(37); check("t6_v37", evt_valid, 0);
    at(38); check("t6_v38", evt_valid, 1); check("t6_code", evt_code, 2'b01);
    at(39); check("t6_v39", evt_valid, 0);

    // 7: asynchronous reset clears a pending event between clock edges
    start();
    evt_ready = 1'b0;
    pulse(10);
    at(18); check("t7_v18", evt_valid, 1);
    at(20);
    rst_l = 1'b0;
    #1;
    check("t7_rst_valid", evt_valid, 0);
    check("t7_rst_code", evt_code, 0);
`ifdef CLICK_DECODER_STATS_EN
    check("t7_rst_evt_cnt", evt_cnt, 0);
    check("t7_rst_drop_cnt", drop_cnt, 0);
`endif
    at(22);
    rst_l = 1'b1;
    evt_ready = 1'b1;
    at(32); check("t7_v32", evt_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
